// File: rtl/led_pattern_engine_if.sv
// led_pattern_engine_if
//   Groups the LED pattern engine's control inputs and display outputs so the
//   board top can hand the whole bundle to the engine as one port.
//
//   Control (board -> engine):
//     i_enable  prescaler count enable
//     i_sel     prescaler period select (DIV0..DIV3)
//     i_dir     rotate direction: 0 = toward MSB, 1 = toward LSB
//     i_btn     raw buttons: [0] next mode, [1] next colour, [2] pause, [3] restart
//   Display (engine -> board):
//     o_led_r/g/b  per-channel LED bank, NB_LED wide
//     o_mode       current animation mode
//     o_color      one-hot colour selection (001 R, 010 G, 100 B)
//     o_pause      pause state
//     o_tick       registered prescaler tick
//
//   master: the side driving the controls (board top / testbench)
//   slave:  the engine itself
interface led_pattern_engine_if #(
  parameter int NB_LED = 4
);
  logic              i_enable;
  logic [1:0]        i_sel;
  logic              i_dir;
  logic [3:0]        i_btn;
  logic [NB_LED-1:0] o_led_r;
  logic [NB_LED-1:0] o_led_g;
  logic [NB_LED-1:0] o_led_b;
  logic [1:0]        o_mode;
  logic [2:0]        o_color;
  logic              o_pause;
  logic              o_tick;

  modport master (
    output i_enable, i_sel, i_dir, i_btn,
    input  o_led_r, o_led_g, o_led_b, o_mode, o_color, o_pause, o_tick
  );

  modport slave (
    input  i_enable, i_sel, i_dir, i_btn,
    output o_led_r, o_led_g, o_led_b, o_mode, o_color, o_pause, o_tick
  );
endinterface

// File: rtl/led_pattern_engine.sv
// led_pattern_engine
//   Drives the board LED bank with one of four animations (rotate, flash,
//   bounce, binary count) stepped by a selectable-rate prescaler, shown on one
//   RGB channel at a time. Four push-buttons are synchronised and debounced
//   here and each press yields a single one-cycle action pulse.
//
//   Ports:
//     clock    system clock
//     i_reset  asynchronous, active-low reset
//     bus      led_pattern_engine_if.slave: control inputs and LED/status outputs
//
//   Parameters:
//     NB_LED      pattern width (>= 2)
//     NB_CNT      prescaler counter width
//     DIV0..DIV3  prescaler period in clocks for i_sel = 0..3 (1 .. 2**NB_CNT-1)
//     DEB_CYCLES  cycles a button must hold a new level before it is accepted
module led_pattern_engine #(
  parameter int NB_LED     = 4,
  parameter int NB_CNT     = 32,
  parameter int DIV0       = 2**23,
  parameter int DIV1       = 2**24,
  parameter int DIV2       = 2**25,
  parameter int DIV3       = 2**26,
  parameter int DEB_CYCLES = 16
) (
  input  logic              clock,
  input  logic              i_reset,
  led_pattern_engine_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_ROT    = 2'd0,
    MODE_FLASH  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_t;

  localparam int NB_DEB = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [NB_DEB-1:0] DEB_LAST = NB_DEB'(DEB_CYCLES - 1);

  // Prescaler state
  logic [NB_CNT-1:0] cnt_q, cnt_d;
  logic              tick_q, tick_d;
  logic [NB_CNT-1:0] div_last;

  // Button synchroniser / debouncer state
  logic [3:0]             sync1_q, sync1_d;
  logic [3:0]             sync2_q, sync2_d;
  logic [3:0]             deb_q, deb_d;
  logic [3:0]             deb_prev_q, deb_prev_d;
  logic [3:0][NB_DEB-1:0] stab_q, stab_d;
  logic [3:0]             press;

  // Animation state
  mode_t             mode_q, mode_d;
  logic [2:0]        color_q, color_d;
  logic              pause_q, pause_d;
  logic [NB_LED-1:0] pattern_q, pattern_d;
  logic              bdir_q, bdir_d;
  logic [NB_LED-1:0] bounce_next;

  // Starting pattern for each mode: single lit LSB for the one-hot modes,
  // all dark for flash and count.
  function automatic logic [NB_LED-1:0] init_pattern(input mode_t m);
    logic [NB_LED-1:0] p;
    p = '0;
    if (m == MODE_ROT || m == MODE_BOUNCE) begin
      p = NB_LED'(1);
    end
    return p;
  endfunction

  // Prescaler. The >= compare lets a switch to a shorter period wrap at once
  // instead of counting all the way round the counter.
  always_comb begin
    div_last = NB_CNT'(DIV0 - 1);
    case (bus.i_sel)
      2'd0:    div_last = NB_CNT'(DIV0 - 1);
      2'd1:    div_last = NB_CNT'(DIV1 - 1);
      2'd2:    div_last = NB_CNT'(DIV2 - 1);
      default: div_last = NB_CNT'(DIV3 - 1);
    endcase

    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (bus.i_enable) begin
      if (cnt_q >= div_last) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + NB_CNT'(1);
      end
    end
  end

  // Buttons: two-flop synchroniser, then a per-bit stability counter that
  // accepts a new level only after it has differed from the debounced level
  // for DEB_CYCLES consecutive cycles. Any return to the old level restarts it.
  always_comb begin
    sync1_d    = bus.i_btn;
    sync2_d    = sync1_q;
    deb_prev_d = deb_q;
    deb_d      = deb_q;
    stab_d     = stab_q;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        stab_d[i] = '0;
      end else if (stab_q[i] == DEB_LAST) begin
        deb_d[i]  = sync2_q[i];
        stab_d[i] = '0;
      end else begin
        stab_d[i] = stab_q[i] + NB_DEB'(1);
      end
    end
  end

  // Rising edge of the debounced level only; releases do nothing.
  assign press = deb_q & ~deb_prev_q;

  // Bounce step: move one place in the current direction and turn around as
  // soon as an end is reached, so the following step heads back.
  always_comb begin
    bounce_next = pattern_q;
    if (!bdir_q) begin
      bounce_next = pattern_q << 1;
    end else begin
      bounce_next = pattern_q >> 1;
    end
  end

  // Mode / colour / pause / pattern next state. A pattern load from the mode
  // or restart button wins over a tick advance in the same cycle; when both
  // buttons fire together the load uses the newly selected mode.
  always_comb begin
    mode_d    = mode_q;
    color_d   = color_q;
    pause_d   = pause_q ^ press[2];
    pattern_d = pattern_q;
    bdir_d    = bdir_q;

    if (press[0]) begin
      mode_d = mode_t'(mode_q + 2'd1);
    end

    if (press[1]) begin
      color_d = {color_q[1:0], color_q[2]};
    end

    if (press[0] || press[3]) begin
      pattern_d = init_pattern(mode_d);
      bdir_d    = 1'b0;
    end else if (tick_q && !pause_q) begin
      unique case (mode_q)
        MODE_ROT: begin
          if (bus.i_dir) begin
            pattern_d = {pattern_q[0], pattern_q[NB_LED-1:1]};
          end else begin
            pattern_d = {pattern_q[NB_LED-2:0], pattern_q[NB_LED-1]};
          end
        end
        MODE_FLASH: begin
          pattern_d = ~pattern_q;
        end
        MODE_BOUNCE: begin
          pattern_d = bounce_next;
          if (!bdir_q && bounce_next[NB_LED-1]) begin
            bdir_d = 1'b1;
          end else if (bdir_q && bounce_next[0]) begin
            bdir_d = 1'b0;
          end
        end
        MODE_COUNT: begin
          pattern_d = pattern_q + NB_LED'(1);
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q      <= '0;
      tick_q     <= 1'b0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      stab_q     <= '0;
      mode_q     <= MODE_ROT;
      color_q    <= 3'b001;
      pause_q    <= 1'b0;
      pattern_q  <= NB_LED'(1);
      bdir_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      tick_q     <= tick_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      stab_q     <= stab_d;
      mode_q     <= mode_d;
      color_q    <= color_d;
      pause_q    <= pause_d;
      pattern_q  <= pattern_d;
      bdir_q     <= bdir_d;
    end
  end

  // Only the selected colour channel shows the pattern.
  assign bus.o_led_r = color_q[0] ? pattern_q : '0;
  assign bus.o_led_g = color_q[1] ? pattern_q : '0;
  assign bus.o_led_b = color_q[2] ? pattern_q : '0;
  assign bus.o_mode  = mode_q;
  assign bus.o_color = color_q;
  assign bus.o_pause = pause_q;
  assign bus.o_tick  = tick_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// tb_led_pattern_engine
//   Directed bench for led_pattern_engine with small prescaler periods
//   (DIV0=4, DIV1=1) and DEB_CYCLES=4. The stimulus process pushes the
//   expected display state for a given cycle into a scoreboard queue; a
//   monitor on the falling clock edge pops and compares it.
module tb_led_pattern_engine;

  localparam int NB_LED = 4;

  typedef struct {
    string      name;
    int         cycle;
    logic [3:0] pat;
    logic [1:0] mode;
    logic [2:0] color;
    logic       pause;
    logic       tick;
  } exp_t;

  logic clock   = 1'b0;
  logic i_reset = 1'b0;
  int   cyc     = 0;
  int   n_vec   = 0;
  int   n_err   = 0;

  exp_t sb_q[$];

  logic [1:0] exp_mode  = 2'd0;
  logic [2:0] exp_color = 3'b001;
  logic       exp_pause = 1'b0;

  led_pattern_engine_if #(.NB_LED(NB_LED)) bus ();

  led_pattern_engine #(
    .NB_LED     (NB_LED),
    .NB_CNT     (8),
    .DIV0       (4),
    .DIV1       (1),
    .DIV2       (2),
    .DIV3       (6),
    .DEB_CYCLES (4)
  ) dut (
    .clock   (clock),
    .i_reset (i_reset),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Drive point: 1 time unit after a rising edge.
  task automatic nextEdge();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic [1:0] sel, input logic dir);
    bus.i_enable = en;
    bus.i_sel    = sel;
    bus.i_dir    = dir;
  endtask

  // Queue the expected display state for the current cycle.
  task automatic checkOutput(input string name, input logic [3:0] pat, input logic tick);
    exp_t e;
    e.name  = name;
    e.cycle = cyc;
    e.pat   = pat;
    e.mode  = exp_mode;
    e.color = exp_color;
    e.pause = exp_pause;
    e.tick  = tick;
    sb_q.push_back(e);
  endtask

  // One tick with DIV1 = 1, then stop; prescaler count returns to 0.
  task automatic stepPattern(input string name, input logic [3:0] exp_pat);
    applyStimulus(1'b1, 2'd1, bus.i_dir);
    nextEdge();
    applyStimulus(1'b0, 2'd1, bus.i_dir);
    nextEdge();
    checkOutput(name, exp_pat, 1'b0);
  endtask

  // Full press: held well beyond the debounce window, then released and
  // allowed to settle so the next press starts clean.
  task automatic pressBtn(input int b);
    bus.i_btn[b] = 1'b1;
    repeat (10) nextEdge();
    bus.i_btn[b] = 1'b0;
    repeat (10) nextEdge();
  endtask

  // Scoreboard monitor
  always @(negedge clock) begin
    exp_t       e;
    logic [3:0] er, eg, eb;
    while (sb_q.size() > 0 && sb_q[0].cycle <= cyc) begin
      e  = sb_q.pop_front();
      er = e.color[0] ? e.pat : 4'b0000;
      eg = e.color[1] ? e.pat : 4'b0000;
      eb = e.color[2] ? e.pat : 4'b0000;
      n_vec++;
      if (e.cycle != cyc ||
          {bus.o_led_r, bus.o_led_g, bus.o_led_b, bus.o_mode, bus.o_color, bus.o_pause, bus.o_tick}
          !== {er, eg, eb, e.mode, e.color, e.pause, e.tick}) begin
        n_err++;
        $display("[TB] FAIL %s @%0d: got r=%b g=%b b=%b mode=%0d color=%b pause=%b tick=%b, expected r=%b g=%b b=%b mode=%0d color=%b pause=%b tick=%b",
                 e.name, e.cycle, bus.o_led_r, bus.o_led_g, bus.o_led_b, bus.o_mode, bus.o_color,
                 bus.o_pause, bus.o_tick, er, eg, eb, e.mode, e.color, e.pause, e.tick);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [3:0]  pat;
    logic [27:0] bseq;

    bus.i_enable = 1'b0;
    bus.i_sel    = 2'd0;
    bus.i_dir    = 1'b0;
    bus.i_btn    = 4'b0000;
    i_reset      = 1'b0;

    repeat (2) nextEdge();
    checkOutput("reset_state", 4'b0001, 1'b0);
    i_reset = 1'b1;

    // Rotate toward MSB, DIV0 = 4, including the wrap back to 0001
    applyStimulus(1'b1, 2'd0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      nextEdge();
      checkOutput($sformatf("rot_up_%0d", k), 4'b0001 << (((k - 1) / 4) % 4), (k % 4) == 0);
    end

    // Reverse direction without reload
    applyStimulus(1'b1, 2'd0, 1'b1);
    for (int k = 21; k <= 32; k++) begin
      nextEdge();
      pat = 4'b0001;
      for (int j = 0; j < (k - 21) / 4 + 1; j++) pat = {pat[0], pat[3:1]};
      checkOutput($sformatf("rot_down_%0d", k), pat, (k % 4) == 0);
    end

    applyStimulus(1'b0, 2'd0, 1'b1);
    nextEdge();
    checkOutput("rot_last_tick", 4'b0001, 1'b0);
    applyStimulus(1'b0, 2'd0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      nextEdge();
      checkOutput("enable_low_hold", 4'b0001, 1'b0);
    end

    // Count must hold its value while disabled
    applyStimulus(1'b1, 2'd0, 1'b0);
    repeat (2) nextEdge();
    checkOutput("count_partial", 4'b0001, 1'b0);
    applyStimulus(1'b0, 2'd0, 1'b0);
    repeat (5) nextEdge();
    checkOutput("count_frozen", 4'b0001, 1'b0);
    applyStimulus(1'b1, 2'd0, 1'b0);
    nextEdge();
    checkOutput("count_resume_3", 4'b0001, 1'b0);
    nextEdge();
    checkOutput("count_resume_tick", 4'b0001, 1'b1);
    applyStimulus(1'b0, 2'd0, 1'b0);
    nextEdge();
    checkOutput("count_resume_step", 4'b0010, 1'b0);

    // DIV1 = 1: tick stays high while enabled
    applyStimulus(1'b1, 2'd1, 1'b0);
    nextEdge(); checkOutput("div1_tick_1", 4'b0010, 1'b1);
    nextEdge(); checkOutput("div1_tick_2", 4'b0100, 1'b1);
    nextEdge(); checkOutput("div1_tick_3", 4'b1000, 1'b1);
    applyStimulus(1'b0, 2'd1, 1'b0);
    nextEdge(); checkOutput("div1_stop", 4'b0001, 1'b0);
    stepPattern("step_rot_a", 4'b0010);
    stepPattern("step_rot_b", 4'b0100);

    // Restart in ROT at 0100; action lands at edge DEB_CYCLES+3 = 7
    bus.i_btn[3] = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      nextEdge();
      if (e == 6) checkOutput("restart_before", 4'b0100, 1'b0);
      if (e == 7) checkOutput("restart_rot", 4'b0001, 1'b0);
    end
    bus.i_btn[3] = 1'b0;
    repeat (10) nextEdge();

    // Restart coinciding with a tick: the load wins
    bus.i_btn[3] = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      nextEdge();
      if (e == 5) applyStimulus(1'b1, 2'd1, 1'b0);
      if (e == 6) begin
        checkOutput("restart_tick_pre", 4'b0001, 1'b1);
        applyStimulus(1'b0, 2'd1, 1'b0);
      end
      if (e == 7) checkOutput("restart_over_tick", 4'b0001, 1'b0);
    end
    bus.i_btn[3] = 1'b0;
    repeat (10) nextEdge();

    // Hold mode button 20 cycles: exactly one advance, at edge 7
    bus.i_btn[0] = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      nextEdge();
      if (e == 6) checkOutput("mode_before", 4'b0001, 1'b0);
      if (e == 7) begin
        exp_mode = 2'd1;
        checkOutput("mode_flash_load", 4'b0000, 1'b0);
      end
      if (e == 20) checkOutput("mode_held", 4'b0000, 1'b0);
    end
    bus.i_btn[0] = 1'b0;
    repeat (10) nextEdge();
    checkOutput("mode_after_release", 4'b0000, 1'b0);
    stepPattern("flash_1", 4'b1111);
    stepPattern("flash_2", 4'b0000);

    // Glitch shorter than the debounce window
    bus.i_btn[0] = 1'b1;
    repeat (3) nextEdge();
    bus.i_btn[0] = 1'b0;
    repeat (12) nextEdge();
    checkOutput("glitch_ignored", 4'b0000, 1'b0);

    // Bounce
    pressBtn(0);
    exp_mode = 2'd2;
    checkOutput("mode_bounce_load", 4'b0001, 1'b0);
    bseq = 28'h2484212;
    for (int i = 0; i < 7; i++) begin
      stepPattern($sformatf("bounce_%0d", i), bseq[27 - 4 * i -: 4]);
    end

    // Count, with wrap
    pressBtn(0);
    exp_mode = 2'd3;
    checkOutput("mode_count_load", 4'b0000, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      stepPattern($sformatf("count_%0d", i), 4'(i));
    end

    pressBtn(0);
    exp_mode = 2'd0;
    checkOutput("mode_wrap_rot", 4'b0001, 1'b0);

    // Colour cycling keeps the pattern
    pressBtn(1);
    exp_color = 3'b010;
    checkOutput("color_g", 4'b0001, 1'b0);
    stepPattern("green_step", 4'b0010);
    pressBtn(1);
    exp_color = 3'b100;
    checkOutput("color_b", 4'b0010, 1'b0);
    pressBtn(1);
    exp_color = 3'b001;
    checkOutput("color_r", 4'b0010, 1'b0);

    // Pause freezes the pattern but not the ticks
    pressBtn(2);
    exp_pause = 1'b1;
    checkOutput("pause_on", 4'b0010, 1'b0);
    applyStimulus(1'b1, 2'd0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      nextEdge();
      checkOutput($sformatf("paused_%0d", k), 4'b0010, (k % 4) == 0);
    end
    applyStimulus(1'b0, 2'd0, 1'b0);
    nextEdge();
    checkOutput("paused_tick_drop", 4'b0010, 1'b0);
    pressBtn(2);
    exp_pause = 1'b0;
    checkOutput("pause_off", 4'b0010, 1'b0);
    stepPattern("resume", 4'b0100);

    // Asynchronous reset with a button mid-debounce
    pressBtn(1);
    exp_color = 3'b010;
    checkOutput("pre_reset_green", 4'b0100, 1'b0);
    bus.i_btn[0] = 1'b1;
    repeat (4) nextEdge();
    i_reset   = 1'b0;
    bus.i_btn = 4'b0000;
    exp_color = 3'b001;
    exp_mode  = 2'd0;
    exp_pause = 1'b0;
    checkOutput("async_reset", 4'b0001, 1'b0);
    nextEdge();
    checkOutput("reset_held", 4'b0001, 1'b0);
    i_reset = 1'b1;
    repeat (12) nextEdge();
    checkOutput("no_pulse_after_reset", 4'b0001, 1'b0);

    repeat (2) nextEdge();
    if (sb_q.size() != 0) begin
      n_err++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending entries, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/led_pattern_engine.md
# led_pattern_engine

Parametrised LED pattern engine for the board LED bank: a selectable-rate prescaler drives one of four animation modes (rotate, flash, bounce, binary count) across NB_LED outputs, routed to one RGB colour channel. Four push-buttons, synchronised and debounced in-block, produce one pulse per press to change mode, cycle the colour, pause, or restart the pattern. The block sits directly under the board top, between the switch/button pins and the RGB LED pins.

## Interface
- NB_LED, 4: pattern width, ≥ 2
- NB_CNT, 32: prescaler counter width
- DIV0 / DIV1 / DIV2 / DIV3, 2**23 / 2**24 / 2**25 / 2**26: prescaler period in clock cycles for i_sel = 0..3, each ≥ 1 and < 2**NB_CNT
- DEB_CYCLES, 16: cycles a synchronised button level must differ from its debounced level before it is accepted, ≥ 1
- clock  in  1  system clock
- i_reset  in  1  reset, asynchronous, active-low
- i_enable  in  1  prescaler count enable
- i_sel  in  2  prescaler period select
- i_dir  in  1  rotate direction: 0 = toward MSB, 1 = toward LSB
- i_btn  in  4  raw buttons: [0] next mode, [1] next colour, [2] pause toggle, [3] restart
- o_led_r / o_led_g / o_led_b  out  NB_LED  channel outputs
- o_mode  out  2  current mode: 0 ROT, 1 FLASH, 2 BOUNCE, 3 COUNT
- o_color  out  3  one-hot colour: 001 R, 010 G, 100 B
- o_pause  out  1  pause state
- o_tick  out  1  registered prescaler tick

## Operation
- Reset values: prescaler count 0, o_tick 0, o_mode 0, o_color 001, o_pause 0, pattern 1 (LSB on), bounce direction up, all synchroniser/debounce state 0. Hence o_led_r = 1, o_led_g = o_led_b = 0.
- Prescaler: with i_enable = 1, if count ≥ DIVsel−1, count ← 0 and o_tick ← 1; otherwise count+1 and o_tick ← 0. With i_enable = 0, count holds and o_tick ← 0. The ≥ compare covers an i_sel change to a shorter period. Ticks continue while paused.
- Buttons, per bit: 2-flop synchroniser → debouncer. If sync == deb, the stability counter clears. Otherwise it increments; at DEB_CYCLES−1, deb ← sync and the counter clears. A press pulse is deb & ~deb_prev, one cycle wide. Releases generate nothing.
- Pattern advances on each cycle with o_tick = 1 and o_pause = 0:
  - ROT: one-hot rotate, with wrap, by i_dir.
  - FLASH: bitwise invert (0 ↔ all ones).
  - BOUNCE: one-hot moves up. At the MSB the direction flips, so the next step goes down. At the LSB it flips up. With NB_LED = 2 it alternates between the two bits.
  - COUNT: +1 modulo 2**NB_LED.
- Initial pattern per mode: ROT 1, FLASH 0, BOUNCE 1 with direction up, COUNT 0.
- Press [0]: mode ← (mode+1) mod 4, and the pattern loads the new mode's initial value.
- Press [1]: colour rotates R→G→B→R. The pattern is unaffected.
- Press [2]: toggles pause.
- Press [3]: the pattern loads the current mode's initial value.
- Simultaneous events:
  - Any pattern load from [0] or [3] overrides a same-cycle tick advance.
  - [0] + [3] in one cycle gives a mode advance plus the new mode's initial value.
  - [1] and [2] act independently of all others in the same cycle.
- Output routing: the selected channel equals the pattern, and the other two are 0. Outputs are combinational from registers only.
- i_dir is sampled at each advance. A change takes effect at the next advance, with no pattern reload.

## Timing
- Prescaler: the first o_tick is high in the cycle after the DIVsel-th enabled rising edge from count 0. Ticks then recur every DIVsel enabled cycles. With DIVsel = 1, o_tick stays high while enabled.
- Pattern update lands on the rising edge where o_tick = 1 is sampled, one cycle after the tick asserts.
- Button latency: number rising edges from 1, where edge 1 is the first edge sampling the raw button high. Then deb rises at edge DEB_CYCLES+2, and the state change (mode/colour/pause/pattern) is visible after edge DEB_CYCLES+3.
- A glitch shorter than DEB_CYCLES synchronised cycles produces no pulse.
- Holding a button gives exactly one action.
- Reset asserted mid-operation immediately forces all reset values, without waiting for a clock. Deassertion is synchronised externally.

## Test plan
- Reset, DIV0 = 4, i_sel = 0, i_enable = 1, ROT, i_dir = 0 → o_led_r steps 0001→0010→0100→1000→0001 every 4 cycles, with o_tick pulsing 1 cycle in 4. Set i_dir = 1 → the sequence reverses.
- DEB_CYCLES = 4, hold i_btn[0] 20 cycles → o_mode 0→1 exactly once, at edge 7. The pattern reads 0000 then 1111 after the next tick. A 3-cycle pulse on i_btn[0] → no change.
- BOUNCE, NB_LED = 4 → 0001,0010,0100,1000,0100,0010,0001,0010. COUNT → 0000..1111 then wraps to 0000.
- Press [1] three times → o_color 010, 100, 001. The pattern moves to o_led_g, then o_led_b, then o_led_r, with identical values.
- Press [2] → pattern frozen while o_tick keeps pulsing. Press [2] again → resumes. Press [3] in ROT at 0100 → 0001. Press [3] timed to coincide with a tick → 0001, not 0010.
- i_enable = 0 → count and pattern hold, o_tick = 0. Assert i_reset low mid-pattern with a button mid-debounce → outputs return to reset values immediately, and no pulse follows deassertion.
